// File: rtl/lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_receiver
// Brief    : Accepts slot-address / character byte pairs from the digit-slot
//            bus and turns each pair into HD44780 set-DDRAM + write-data
//            cycles; runs the panel power-up init before unlocking the bus.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_receiver #(
  parameter int         NUM_CHARS         = 5,
  parameter logic [7:0] DDRAM_BASE        = 8'h00,
  parameter int         SETUP_CYCLES      = 3,
  parameter int         E_PULSE_CYCLES    = 12,
  parameter int         CMD_WAIT_CYCLES   = 2500,
  parameter int         CLEAR_WAIT_CYCLES = 82000,
  parameter int         PWRUP_WAIT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       addr_or_data,
  input  logic [7:0] lcd_bus_in,
  output logic       bus_lock,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       init_done
);

  localparam int c_MAX_A = (SETUP_CYCLES > E_PULSE_CYCLES) ? SETUP_CYCLES : E_PULSE_CYCLES;
  localparam int c_MAX_B = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int c_MAX_C = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_MAX   = (c_MAX_C > PWRUP_WAIT_CYCLES) ? c_MAX_C : PWRUP_WAIT_CYCLES;
  localparam int CW      = $clog2(c_MAX + 1);

  typedef enum logic [2:0] {
    ST_PWRUP   = 3'd0,
    ST_INIT    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_EHIGH = 2'd1,
    PH_WAIT  = 2'd2
  } phase_t;

  state_t        r_state;
  phase_t        r_phase;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [7:0]    r_slot;
  logic [7:0]    r_char;
  logic          r_addr_valid;
  logic          r_bus_lock;
  logic          r_rs;
  logic          r_e;
  logic [7:0]    r_db;
  logic          r_init_done;

  logic          w_cnt_zero;
  logic [CW-1:0] w_wait_load;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_wait_load = (!r_rs && r_db == 8'h01) ? CW'(CLEAR_WAIT_CYCLES - 1)
                                                : CW'(CMD_WAIT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_PWRUP;
      r_phase      <= PH_SETUP;
      r_cnt        <= CW'(PWRUP_WAIT_CYCLES - 1);
      r_idx        <= 2'd0;
      r_slot       <= 8'h00;
      r_char       <= 8'h00;
      r_addr_valid <= 1'b0;
      r_bus_lock   <= 1'b1;
      r_rs         <= 1'b0;
      r_e          <= 1'b0;
      r_db         <= 8'h00;
      r_init_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_PWRUP: begin
          if (w_cnt_zero) begin
            r_state <= ST_INIT;
            r_idx   <= 2'd0;
            r_rs    <= 1'b0;
            r_db    <= init_cmd(2'd0);
            r_phase <= PH_SETUP;
            r_cnt   <= CW'(SETUP_CYCLES - 1);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        ST_IDLE: begin
          if (!r_bus_lock) begin
            if (!addr_or_data) begin
              if (int'(lcd_bus_in) < NUM_CHARS) begin
                r_slot       <= lcd_bus_in;
                r_addr_valid <= 1'b1;
              end else begin
                r_addr_valid <= 1'b0;
              end
            end else if (r_addr_valid) begin
              r_char       <= lcd_bus_in;
              r_addr_valid <= 1'b0;
              r_bus_lock   <= 1'b1;
              r_state      <= ST_WR_ADDR;
              r_rs         <= 1'b0;
              r_db         <= 8'h80 | (DDRAM_BASE + r_slot);
              r_phase      <= PH_SETUP;
              // The accept cycle itself precedes the setup window, so E rises one cycle later.
              r_cnt        <= CW'(SETUP_CYCLES);
            end
          end
        end

        default: begin
          case (r_phase)
            PH_SETUP: begin
              if (w_cnt_zero) begin
                r_e     <= 1'b1;
                r_phase <= PH_EHIGH;
                r_cnt   <= CW'(E_PULSE_CYCLES - 1);
              end else begin
                r_cnt <= r_cnt - CW'(1);
              end
            end
            PH_EHIGH: begin
              if (w_cnt_zero) begin
                r_e     <= 1'b0;
                r_phase <= PH_WAIT;
                r_cnt   <= w_wait_load;
              end else begin
                r_cnt <= r_cnt - CW'(1);
              end
            end
            default: begin
              if (w_cnt_zero) begin
                r_phase <= PH_SETUP;
                r_cnt   <= CW'(SETUP_CYCLES - 1);
                case (r_state)
                  ST_INIT: begin
                    if (r_idx == 2'd3) begin
                      r_state     <= ST_IDLE;
                      r_init_done <= 1'b1;
                      r_bus_lock  <= 1'b0;
                    end else begin
                      r_idx <= r_idx + 2'd1;
                      r_db  <= init_cmd(r_idx + 2'd1);
                    end
                  end
                  ST_WR_ADDR: begin
                    r_state <= ST_WR_DATA;
                    r_rs    <= 1'b1;
                    r_db    <= r_char;
                  end
                  default: begin
                    r_state    <= ST_IDLE;
                    r_bus_lock <= 1'b0;
                  end
                endcase
              end else begin
                r_cnt <= r_cnt - CW'(1);
              end
            end
          endcase
        end
      endcase
    end
  end

  assign bus_lock  = r_bus_lock;
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = r_e;
  assign lcd_db    = r_db;
  assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_receiver
// Brief    : Scoreboard bench for lcd_bus_receiver; expected LCD writes are
//            queued by the stimulus and popped on every rising edge of E.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_receiver;

  localparam int S  = 1;
  localparam int EP = 2;
  localparam int W  = 4;
  localparam int CL = 8;
  localparam int P  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       addr_or_data;
  logic [7:0] lcd_bus_in;
  logic       bus_lock;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       init_done;

  always #5 clk = ~clk;

  lcd_bus_receiver #(
    .NUM_CHARS(5), .DDRAM_BASE(8'h00), .SETUP_CYCLES(S), .E_PULSE_CYCLES(EP),
    .CMD_WAIT_CYCLES(W), .CLEAR_WAIT_CYCLES(CL), .PWRUP_WAIT_CYCLES(P)
  ) dut (
    .clk(clk), .rst(rst), .addr_or_data(addr_or_data), .lcd_bus_in(lcd_bus_in),
    .bus_lock(bus_lock), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_db(lcd_db), .init_done(init_done)
  );

  // gap = expected E-low cycles before this write's rising edge (0: not checked)
  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         gap;
  } wr_t;

  wr_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_rs1    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic rs_v, input logic [7:0] db_v, input int gap_v);
    wr_t e;
    e.rs = rs_v; e.db = db_v; e.gap = gap_v;
    q.push_back(e);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, 0);
    push(1'b0, 8'h0C, W + S);
    push(1'b0, 8'h01, W + S);
    push(1'b0, 8'h06, CL + S);
  endtask

  // Monitor: pops one expected write per E rising edge, checks pulse width and gaps.
  int  hi_cnt = 0;
  int  lo_cnt = 0;
  logic prev_e = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      prev_e = 1'b0; hi_cnt = 0; lo_cnt = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        if (q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("write_rs", {31'd0, lcd_rs}, {31'd0, e.rs});
          chk("write_db", {24'd0, lcd_db}, {24'd0, e.db});
          chk("write_rw", {31'd0, lcd_rw}, 32'd0);
          if (e.gap != 0) chk("write_gap", lo_cnt, e.gap);
        end
        if (lcd_rs) n_rs1++;
        hi_cnt = 1;
      end else if (lcd_e) begin
        hi_cnt++;
      end else if (prev_e) begin
        chk("e_width", hi_cnt, EP);
        lo_cnt = 1;
      end else begin
        lo_cnt++;
      end
      prev_e = lcd_e;
    end
  end

  task automatic send(input logic aod, input logic [7:0] b, input string name);
    int n;
    @(negedge clk);
    addr_or_data = aod;
    lcd_bus_in   = b;
    n = 0;
    while (bus_lock && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus_lock) chk({name, "_accept_timeout"}, {31'd0, bus_lock}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_unlock(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_lock && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_unlock"}, {31'd0, bus_lock}, 32'd0);
    chk({name, "_queue_empty"}, q.size(), 32'd0);
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_init_done"}, {31'd0, init_done}, 32'd1);
    chk({name, "_bus_lock"}, {31'd0, bus_lock}, 32'd0);
    chk({name, "_init_writes"}, q.size(), 32'd0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int locked;
    locked = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus_lock) locked++;
    end
    chk({name, "_no_lock"}, locked, 32'd0);
    chk({name, "_no_write"}, q.size(), 32'd0);
  endtask

  initial begin
    int n;
    int rs1_before;
    rst          = 1'b0;
    addr_or_data = 1'b0;
    lcd_bus_in   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_bus_lock", {31'd0, bus_lock}, 32'd1);
    chk("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_lcd_db", {24'd0, lcd_db}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);

    push_init();
    @(negedge clk);
    rst = 1'b1;
    wait_init("init1");

    // Addr 2, char '7': DDRAM command 0x82 then data 0x37, E rises S+1 after accept.
    push(1'b0, 8'h82, 0);
    push(1'b1, 8'h37, W + S);
    send(1'b0, 8'h02, "pair1_addr");
    send(1'b1, 8'h37, "pair1_data");
    chk("pair1_lock_on_accept", {31'd0, bus_lock}, 32'd1);
    n = 0;
    while (!lcd_e && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pair1_latency", n, S + 1);
    wait_unlock("pair1");

    send(1'b1, 8'h35, "orphan_data");
    quiet("orphan", 10);

    send(1'b0, 8'h07, "bad_addr");
    send(1'b1, 8'h41, "bad_addr_data");
    quiet("bad_addr", 10);

    push(1'b0, 8'h84, 0);
    push(1'b1, 8'h39, W + S);
    send(1'b0, 8'h01, "last_wins_a1");
    send(1'b0, 8'h04, "last_wins_a4");
    send(1'b1, 8'h39, "last_wins_data");
    wait_unlock("last_wins");

    // Initiator keeps presenting the same data byte long after acceptance.
    rs1_before = n_rs1;
    push(1'b0, 8'h83, 0);
    push(1'b1, 8'h31, W + S);
    send(1'b0, 8'h03, "hold_addr");
    send(1'b1, 8'h31, "hold_data");
    repeat (20) @(negedge clk);
    wait_unlock("hold");
    repeat (10) @(negedge clk);
    chk("hold_single_data_write", n_rs1 - rs1_before, 32'd1);

    // Reset while the data write's E is high.
    push(1'b0, 8'h80, 0);
    push(1'b1, 8'h41, W + S);
    send(1'b0, 8'h00, "rst_mid_addr");
    send(1'b1, 8'h41, "rst_mid_data");
    n = 0;
    while (!(lcd_e && lcd_rs) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_ehigh", {31'd0, lcd_e & lcd_rs}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_mid_bus_lock", {31'd0, bus_lock}, 32'd1);
    chk("rst_mid_init_done", {31'd0, init_done}, 32'd0);
    q.delete();
    push_init();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_init("init2");
    quiet("after_reinit", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
